// File: rtl/adc_idelay_pkg.sv
// rtl/adc_idelay_pkg.sv - shared constants and FSM state type for the IDELAY tap-load sequencer
package adc_idelay_pkg;

    localparam int N_ADC       = 4;
    localparam int TAP_W       = 5;
    localparam int SEL_W       = 17;
    localparam int IDX_W       = 2;
    // delay_sel bits 15..0 pick data lines, bit 16 picks the ADC clock line
    localparam int SEL_CLK_BIT = 16;

    typedef enum logic [2:0] {
        IDLE,
        CHK_RDY,
        DRIVE,
        LOAD,
        SETTLE,
        VERIFY,
        RESP
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc_idelay_load_sequencer_if.sv
// rtl/adc_idelay_load_sequencer_if.sv - requester-side request/ack bus of the IDELAY sequencer
interface adc_idelay_load_sequencer_if;
    import adc_idelay_pkg::*;

    logic [N_ADC-1:0]       req;
    logic [N_ADC*TAP_W-1:0] req_tap;
    logic [N_ADC*SEL_W-1:0] req_sel;
    logic [N_ADC-1:0]       ack;
    logic [N_ADC-1:0]       err;

    modport master (output req, req_tap, req_sel, input ack, err);
    modport slave  (input req, req_tap, req_sel, output ack, err);

endinterface

// File: rtl/adc_idelay_rr_arbiter.sv
// rtl/adc_idelay_rr_arbiter.sv - combinational round-robin grant: lowest requesting index at or after ptr
module adc_idelay_rr_arbiter
    import adc_idelay_pkg::*;
(
    input  logic [N_ADC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [N_ADC-1:0] gnt_oh,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_oh    = '0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = 0; k < N_ADC; k++) begin
            // N_ADC is a power of two, so the add wraps 3 -> 0 naturally
            idx = ptr + IDX_W'(k);
            if (!gnt_valid && req[idx]) begin
                gnt_valid   = 1'b1;
                gnt_idx     = idx;
                gnt_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_idelay_load_sequencer.sv
// rtl/adc_idelay_load_sequencer.sv - shares the four ADC IDELAY tap-load ports between four requesters
// Optional readback compare in VERIFY: define IDELAY_SEQ_READBACK_CHECK_EN.
module adc_idelay_load_sequencer
    import adc_idelay_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int SETTLE_CYC = 8,
    parameter int RDY_TMO    = 1023
) (
    input  logic                        sys_clk,
    input  logic                        rst_n,
    adc_idelay_load_sequencer_if.slave  req_bus,
    output logic                        busy,
    output logic [N_ADC*TAP_W-1:0]      delay_reg,
    output logic [N_ADC*SEL_W-1:0]      delay_sel,
    output logic [N_ADC-1:0]            delay_load,
    input  logic [N_ADC-1:0]            delay_rdy,
    input  logic [N_ADC*TAP_W-1:0]      delay_reg_read
);

    localparam int CNT_W = $clog2(max3(SETUP_CYC, SETTLE_CYC, RDY_TMO) + 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] gidx_q;
    logic [N_ADC-1:0] goh_q;
    logic [TAP_W-1:0] tap_q;
    logic [SEL_W-1:0] sel_q;
    logic [N_ADC-1:0] ack_q, err_q;
    logic             err_d;

    logic             arb_valid;
    logic [N_ADC-1:0] arb_oh;
    logic [IDX_W-1:0] arb_idx;

    adc_idelay_rr_arbiter u_arb (
        .req       (req_bus.req),
        .ptr       (ptr_q),
        .gnt_valid (arb_valid),
        .gnt_oh    (arb_oh),
        .gnt_idx   (arb_idx)
    );

`ifdef IDELAY_SEQ_READBACK_CHECK_EN
    logic [TAP_W-1:0] rb_tap;
    assign rb_tap = delay_reg_read[gidx_q*TAP_W +: TAP_W];
`else
    logic unused_rb;
    assign unused_rb = ^delay_reg_read;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (arb_valid) state_d = CHK_RDY;
            end
            CHK_RDY: begin
                if (delay_rdy[gidx_q]) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(RDY_TMO - 1)) begin
                    // timeout skips the load entirely and reports straight away
                    state_d = RESP;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: state_d = SETTLE;
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = VERIFY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            VERIFY: begin
                state_d = RESP;
`ifdef IDELAY_SEQ_READBACK_CHECK_EN
                err_d = (rb_tap != tap_q);
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            gidx_q     <= '0;
            goh_q      <= '0;
            tap_q      <= '0;
            sel_q      <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            delay_reg  <= '0;
            delay_sel  <= '0;
            delay_load <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && arb_valid) begin
                gidx_q <= arb_idx;
                goh_q  <= arb_oh;
                tap_q  <= req_bus.req_tap[arb_idx*TAP_W +: TAP_W];
                sel_q  <= req_bus.req_sel[arb_idx*SEL_W +: SEL_W];
            end
            // only the granted slice changes; the other ADCs keep their last setting
            if (state_q == CHK_RDY && state_d == DRIVE) begin
                delay_reg[gidx_q*TAP_W +: TAP_W] <= tap_q;
                delay_sel[gidx_q*SEL_W +: SEL_W] <= sel_q;
            end
            delay_load <= (state_d == LOAD) ? goh_q : '0;
            ack_q      <= (state_d == RESP) ? goh_q : '0;
            err_q      <= (state_d == RESP && err_d) ? goh_q : '0;
            if (state_q == RESP) ptr_q <= gidx_q + 1'b1;
        end
    end

    assign busy        = (state_q != IDLE);
    assign req_bus.ack = ack_q;
    assign req_bus.err = err_q;

endmodule

// File: tb/tb_adc_idelay_load_sequencer.sv
// tb/tb_adc_idelay_load_sequencer.sv - self-checking bench for adc_idelay_load_sequencer
module tb_adc_idelay_load_sequencer;
    import adc_idelay_pkg::*;

    localparam int SETUP_CYC  = 2;
    localparam int SETTLE_CYC = 8;
    localparam int RDY_TMO    = 1023;
    localparam int LAT_CYC    = 1 + 1 + SETUP_CYC + 1 + SETTLE_CYC + 1 + 1;
`ifdef IDELAY_SEQ_READBACK_CHECK_EN
    localparam logic RB_ERR = 1'b1;
`else
    localparam logic RB_ERR = 1'b0;
`endif

    logic                   sys_clk = 1'b0;
    logic                   rst_n   = 1'b0;
    logic                   busy;
    logic [N_ADC*TAP_W-1:0] delay_reg;
    logic [N_ADC*SEL_W-1:0] delay_sel;
    logic [N_ADC-1:0]       delay_load;
    logic [N_ADC-1:0]       delay_rdy;
    logic [N_ADC*TAP_W-1:0] delay_reg_read;
    logic [N_ADC*TAP_W-1:0] rb_flip;

    adc_idelay_load_sequencer_if bus();

    adc_idelay_load_sequencer #(
        .SETUP_CYC  (SETUP_CYC),
        .SETTLE_CYC (SETTLE_CYC),
        .RDY_TMO    (RDY_TMO)
    ) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .req_bus        (bus),
        .busy           (busy),
        .delay_reg      (delay_reg),
        .delay_sel      (delay_sel),
        .delay_load     (delay_load),
        .delay_rdy      (delay_rdy),
        .delay_reg_read (delay_reg_read)
    );

    always #5 sys_clk = ~sys_clk;

    // IDELAY readback model: echoes the programmed taps, optionally corrupted
    assign delay_reg_read = delay_reg ^ rb_flip;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    int               w_cyc;
    logic [N_ADC-1:0] w_ack, w_err, w_load_or;
    int               w_loads, w_multi;
    logic [TAP_W-1:0] w_tap;
    logic [SEL_W-1:0] w_sel;

    function automatic int rr_next(input logic [N_ADC-1:0] pend, input int ptr);
        for (int k = 0; k < N_ADC; k++)
            if (pend[(ptr + k) % N_ADC]) return (ptr + k) % N_ADC;
        return -1;
    endfunction

    task automatic wait_ack(input int max_cyc);
        w_cyc = -1; w_ack = '0; w_err = '0; w_load_or = '0;
        w_loads = 0; w_multi = 0; w_tap = '0; w_sel = '0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge sys_clk); #1;
            if (delay_load != '0) begin
                w_loads++;
                w_load_or |= delay_load;
                if (!$onehot(delay_load)) w_multi++;
                for (int b = 0; b < N_ADC; b++)
                    if (delay_load[b]) begin
                        w_tap = delay_reg[b*TAP_W +: TAP_W];
                        w_sel = delay_sel[b*SEL_W +: SEL_W];
                    end
            end
            if (bus.ack != '0) begin
                w_ack = bus.ack;
                w_err = bus.err;
                w_cyc = i;
                break;
            end
        end
    endtask

    task automatic start_req(input int idx, input logic [TAP_W-1:0] tap, input logic [SEL_W-1:0] sel);
        @(posedge sys_clk); #1;
        bus.req_tap[idx*TAP_W +: TAP_W] = tap;
        bus.req_sel[idx*SEL_W +: SEL_W] = sel;
        bus.req[idx] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if ({busy, delay_load, bus.ack, bus.err} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b load=%b ack=%b err=%b, want all 0", busy, delay_load, bus.ack, bus.err);
        end
        checks++;
        if (delay_reg !== '0 || delay_sel !== '0) begin
            errors++;
            $display("FAIL reset_data: got reg=%h sel=%h, want 0", delay_reg, delay_sel);
        end
        rst_n = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_back_to_back();
        logic [N_ADC-1:0] pend;
        logic [TAP_W-1:0] taps [N_ADC];
        int exp;
        @(posedge sys_clk); #1;
        for (int i = 0; i < N_ADC; i++) begin
            taps[i] = TAP_W'($urandom);
            bus.req_tap[i*TAP_W +: TAP_W] = taps[i];
            bus.req_sel[i*SEL_W +: SEL_W] = SEL_W'($urandom);
        end
        bus.req = 4'b1111;
        pend = 4'b1111;
        for (int n = 0; n < N_ADC; n++) begin
            exp = rr_next(pend, model_ptr);
            wait_ack(LAT_CYC + 10);
            checks++;
            if (w_cyc != ((n == 0) ? LAT_CYC - 1 : LAT_CYC)) begin
                errors++;
                $display("FAIL b2b_spacing[%0d]: got %0d edges, want %0d", n, w_cyc, (n == 0) ? LAT_CYC - 1 : LAT_CYC);
            end
            checks++;
            if (w_ack !== N_ADC'(1 << exp) || w_err !== '0) begin
                errors++;
                $display("FAIL b2b_order[%0d]: got ack=%b err=%b, want ack=%b err=0", n, w_ack, w_err, N_ADC'(1 << exp));
            end
            checks++;
            if (w_loads != 1 || w_multi != 0 || w_load_or !== N_ADC'(1 << exp) || w_tap !== taps[exp]) begin
                errors++;
                $display("FAIL b2b_load[%0d]: got loads=%0d multi=%0d mask=%b tap=%0d, want 1 0 %b %0d",
                         n, w_loads, w_multi, w_load_or, w_tap, N_ADC'(1 << exp), taps[exp]);
            end
            if (exp >= 0) begin
                bus.req[exp] = 1'b0;
                pend[exp] = 1'b0;
                model_ptr = (exp + 1) % N_ADC;
            end
        end
    endtask

    task automatic test_single();
        start_req(1, 5'd13, 17'h0FFFF);
        wait_ack(LAT_CYC + 10);
        bus.req[1] = 1'b0;
        checks++;
        if (w_cyc != LAT_CYC - 1 || w_ack !== 4'b0010 || w_err !== 4'b0000) begin
            errors++;
            $display("FAIL single_ack: got edges=%0d ack=%b err=%b, want %0d 0010 0000", w_cyc, w_ack, w_err, LAT_CYC - 1);
        end
        checks++;
        if (w_loads != 1 || w_load_or !== 4'b0010 || w_tap !== 5'd13 || w_sel !== 17'h0FFFF) begin
            errors++;
            $display("FAIL single_load: got loads=%0d mask=%b tap=%0d sel=%h, want 1 0010 13 0ffff", w_loads, w_load_or, w_tap, w_sel);
        end
        checks++;
        if (delay_reg[9:5] !== 5'd13) begin
            errors++;
            $display("FAIL single_reg: got %0d want 13", delay_reg[9:5]);
        end
        model_ptr = 2;
    endtask

    task automatic test_latch();
        logic [TAP_W-1:0] tap_a;
        logic [SEL_W-1:0] sel_a;
        tap_a = TAP_W'($urandom);
        sel_a = SEL_W'($urandom);
        start_req(3, tap_a, sel_a);
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL latch_busy: got %b want 1", busy);
        end
        bus.req_tap[3*TAP_W +: TAP_W] = ~tap_a;
        bus.req_sel[3*SEL_W +: SEL_W] = ~sel_a;
        wait_ack(LAT_CYC + 10);
        bus.req[3] = 1'b0;
        checks++;
        if (w_cyc != LAT_CYC - 4 || w_ack !== 4'b1000) begin
            errors++;
            $display("FAIL latch_ack: got edges=%0d ack=%b, want %0d 1000", w_cyc, w_ack, LAT_CYC - 4);
        end
        checks++;
        if (w_tap !== tap_a || w_sel !== sel_a) begin
            errors++;
            $display("FAIL latch_value: got tap=%0d sel=%h, want %0d %h", w_tap, w_sel, tap_a, sel_a);
        end
        model_ptr = 0;
    endtask

    task automatic test_timeout();
        delay_rdy[2] = 1'b0;
        start_req(2, TAP_W'($urandom), SEL_W'($urandom));
        wait_ack(RDY_TMO + 20);
        bus.req[2] = 1'b0;
        delay_rdy[2] = 1'b1;
        checks++;
        if (w_cyc != RDY_TMO + 1) begin
            errors++;
            $display("FAIL tmo_latency: got %0d edges want %0d", w_cyc, RDY_TMO + 1);
        end
        checks++;
        if (w_ack !== 4'b0100 || w_err !== 4'b0100) begin
            errors++;
            $display("FAIL tmo_err: got ack=%b err=%b want 0100 0100", w_ack, w_err);
        end
        checks++;
        if (w_loads != 0) begin
            errors++;
            $display("FAIL tmo_noload: got %0d load pulses want 0", w_loads);
        end
        model_ptr = 3;
    endtask

    task automatic test_readback();
        rb_flip = '0;
        rb_flip[0] = 1'b1;
        start_req(0, TAP_W'($urandom), SEL_W'($urandom));
        wait_ack(LAT_CYC + 10);
        bus.req[0] = 1'b0;
        rb_flip = '0;
        checks++;
        if (w_cyc != LAT_CYC - 1 || w_ack !== 4'b0001 || w_err !== {3'b000, RB_ERR}) begin
            errors++;
            $display("FAIL readback: got edges=%0d ack=%b err=%b, want %0d 0001 %b", w_cyc, w_ack, w_err, LAT_CYC - 1, {3'b000, RB_ERR});
        end
        model_ptr = 1;
    endtask

    task automatic test_reset_mid();
        int idx;
        int acks_seen;
        logic [TAP_W-1:0] tap_b;
        idx = $urandom_range(0, N_ADC - 1);
        start_req(idx, TAP_W'($urandom), SEL_W'($urandom));
        acks_seen = 0;
        repeat (8) begin
            @(posedge sys_clk); #1;
            if (bus.ack != '0) acks_seen++;
        end
        rst_n = 1'b0;
        @(posedge sys_clk); #1;
        checks++;
        if ({busy, delay_load, bus.ack} !== '0 || delay_reg !== '0 || delay_sel !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got busy=%b load=%b ack=%b reg=%h sel=%h, want all 0",
                     busy, delay_load, bus.ack, delay_reg, delay_sel);
        end
        bus.req = '0;
        repeat (2) begin
            @(posedge sys_clk); #1;
            if (bus.ack != '0) acks_seen++;
        end
        rst_n = 1'b1;
        model_ptr = 0;
        repeat (LAT_CYC) begin
            @(posedge sys_clk); #1;
            if (bus.ack != '0) acks_seen++;
        end
        checks++;
        if (acks_seen != 0) begin
            errors++;
            $display("FAIL midrst_noack: got %0d ack cycles want 0", acks_seen);
        end
        idx = $urandom_range(0, N_ADC - 1);
        tap_b = TAP_W'($urandom);
        start_req(idx, tap_b, SEL_W'($urandom));
        wait_ack(LAT_CYC + 10);
        bus.req[idx] = 1'b0;
        checks++;
        if (w_cyc != LAT_CYC - 1 || w_ack !== N_ADC'(1 << idx) || w_tap !== tap_b) begin
            errors++;
            $display("FAIL midrst_recover: got edges=%0d ack=%b tap=%0d, want %0d %b %0d",
                     w_cyc, w_ack, w_tap, LAT_CYC - 1, N_ADC'(1 << idx), tap_b);
        end
        model_ptr = (idx + 1) % N_ADC;
    endtask

    task automatic test_random();
        logic [N_ADC-1:0] pend;
        logic [TAP_W-1:0] taps [N_ADC];
        logic [SEL_W-1:0] sels [N_ADC];
        int exp;
        for (int r = 0; r < 8; r++) begin
            @(posedge sys_clk); #1;
            for (int i = 0; i < N_ADC; i++) begin
                taps[i] = TAP_W'($urandom);
                sels[i] = SEL_W'($urandom);
                bus.req_tap[i*TAP_W +: TAP_W] = taps[i];
                bus.req_sel[i*SEL_W +: SEL_W] = sels[i];
            end
            pend = N_ADC'($urandom_range(1, 15));
            bus.req = pend;
            for (int n = 0; pend != '0; n++) begin
                exp = rr_next(pend, model_ptr);
                wait_ack(LAT_CYC + 10);
                checks++;
                if (w_cyc != ((n == 0) ? LAT_CYC - 1 : LAT_CYC) || w_ack !== N_ADC'(1 << exp) || w_err !== '0) begin
                    errors++;
                    $display("FAIL rand_ack[%0d.%0d]: got edges=%0d ack=%b err=%b, want %0d %b 0000",
                             r, n, w_cyc, w_ack, w_err, (n == 0) ? LAT_CYC - 1 : LAT_CYC, N_ADC'(1 << exp));
                end
                checks++;
                if (w_loads != 1 || w_multi != 0 || w_tap !== taps[exp] || w_sel !== sels[exp]) begin
                    errors++;
                    $display("FAIL rand_load[%0d.%0d]: got loads=%0d multi=%0d tap=%0d sel=%h, want 1 0 %0d %h",
                             r, n, w_loads, w_multi, w_tap, w_sel, taps[exp], sels[exp]);
                end
                if (w_cyc < 0) begin
                    bus.req = '0;
                    pend = '0;
                end else begin
                    bus.req[exp] = 1'b0;
                    pend[exp] = 1'b0;
                    model_ptr = (exp + 1) % N_ADC;
                end
            end
        end
    endtask

    initial begin
        bus.req     = '0;
        bus.req_tap = '0;
        bus.req_sel = '0;
        delay_rdy   = '1;
        rb_flip     = '0;
        test_reset();
        test_back_to_back();
        test_single();
        test_latch();
        test_timeout();
        test_readback();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
